// File: rtl/dnn_job_arb_if.sv
// Bundle of the requester, dnn_top and response signals around dnn_job_arb.
// slave is the arbiter's view; master is the surrounding system's view.
interface dnn_job_arb_if #(
    parameter int OUT_W = 12
);
    logic             req0_valid;
    logic             req0_ready;
    logic [19:0]      req0_x;
    logic [79:0]      req0_w1;
    logic [39:0]      req0_w2;
    logic             req1_valid;
    logic             req1_ready;
    logic [19:0]      req1_x;
    logic [79:0]      req1_w1;
    logic [39:0]      req1_w2;
    logic [19:0]      dnn_x;
    logic [79:0]      dnn_w1;
    logic [39:0]      dnn_w2;
    logic             dnn_in_ready;
    logic [OUT_W-1:0] dnn_out0;
    logic [OUT_W-1:0] dnn_out1;
    logic             dnn_out0_ready;
    logic             dnn_out1_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [OUT_W-1:0] rsp_out0;
    logic [OUT_W-1:0] rsp_out1;
    logic             rsp_err;

    modport slave (
        input  req0_valid, req0_x, req0_w1, req0_w2,
        input  req1_valid, req1_x, req1_w1, req1_w2,
        input  dnn_out0, dnn_out1, dnn_out0_ready, dnn_out1_ready,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output dnn_x, dnn_w1, dnn_w2, dnn_in_ready,
        output rsp_valid, rsp_id, rsp_out0, rsp_out1, rsp_err
    );

    modport master (
        output req0_valid, req0_x, req0_w1, req0_w2,
        output req1_valid, req1_x, req1_w1, req1_w2,
        output dnn_out0, dnn_out1, dnn_out0_ready, dnn_out1_ready,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  dnn_x, dnn_w1, dnn_w2, dnn_in_ready,
        input  rsp_valid, rsp_id, rsp_out0, rsp_out1, rsp_err
    );
endinterface

// File: rtl/dnn_job_arb.sv
// Round-robin job arbiter sharing one dnn_top between two requesters.
// A job is latched on grant, started with a one-cycle dnn_in_ready pulse,
// its two results are collected independently, and the tagged result is
// returned over a valid/ready port. A WAIT timeout aborts with rsp_err.
module dnn_job_arb #(
    parameter int OUT_W   = 12,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input logic            clk,
    input logic            rst,
    dnn_job_arb_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic [19:0] x;
        logic [79:0] w1;
        logic [39:0] w2;
    } job_t;

    state_t                  state;
    logic                    last_grant;
    logic [1:0]              got;
    logic [CNT_W-1:0]        cnt;
    job_t                    ops;
    logic                    in_rdy_q;
    logic                    rsp_vld_q;
    logic                    rsp_id_q;
    logic                    rsp_err_q;
    logic [1:0][OUT_W-1:0]   rsp_q;

    logic [1:0]              vld;
    logic                    gnt_any;
    logic                    gnt_id;
    job_t                    job_sel;
    logic [1:0]              drdy;
    logic [1:0][OUT_W-1:0]   dout;
    logic [1:0]              done;

    // Grant decision: only in IDLE; on contention the requester not served last wins.
    always_comb begin
        vld     = {bus.req1_valid, bus.req0_valid};
        gnt_any = (state == IDLE) && !rst && (|vld);
        gnt_id  = (vld == 2'b11) ? ~last_grant : vld[1];
        job_sel = gnt_id ? {bus.req1_x, bus.req1_w1, bus.req1_w2}
                         : {bus.req0_x, bus.req0_w1, bus.req0_w2};
        drdy    = {bus.dnn_out1_ready, bus.dnn_out0_ready};
        dout    = {bus.dnn_out1, bus.dnn_out0};
        done    = got | drdy;
    end

    assign bus.req0_ready   = gnt_any && !gnt_id;
    assign bus.req1_ready   = gnt_any && gnt_id;
    assign bus.dnn_x        = ops.x;
    assign bus.dnn_w1       = ops.w1;
    assign bus.dnn_w2       = ops.w2;
    assign bus.dnn_in_ready = in_rdy_q;
    assign bus.rsp_valid    = rsp_vld_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_out0     = rsp_q[0];
    assign bus.rsp_out1     = rsp_q[1];
    assign bus.rsp_err      = rsp_err_q;

    // Job sequencer: grant/latch, issue pulse, result collection with timeout, response hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            got        <= '0;
            cnt        <= '0;
            ops        <= '0;
            in_rdy_q   <= 1'b0;
            rsp_vld_q  <= 1'b0;
            rsp_id_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_q      <= '0;
        end else begin
            in_rdy_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        ops        <= job_sel;
                        rsp_id_q   <= gnt_id;
                        last_grant <= gnt_id;
                        rsp_q      <= '0;   // stale results never leak into a new job
                        rsp_err_q  <= 1'b0;
                        in_rdy_q   <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // a result may already show up alongside the start pulse
                    cnt <= '0;
                    got <= drdy;
                    for (int k = 0; k < 2; k++)
                        if (drdy[k]) rsp_q[k] <= dout[k];
                    state <= WAIT;
                end
                WAIT: begin
                    // first capture wins; repeats after got are ignored
                    for (int k = 0; k < 2; k++) begin
                        if (drdy[k] && !got[k]) begin
                            rsp_q[k] <= dout[k];
                            got[k]   <= 1'b1;
                        end
                    end
                    if (&done) begin
                        state     <= RESP;
                        rsp_vld_q <= 1'b1;
                        rsp_err_q <= 1'b0;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state     <= RESP;
                        rsp_vld_q <= 1'b1;
                        rsp_err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_vld_q <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dnn_job_arb.sv
// Directed bench for dnn_job_arb: a table of jobs (requesters, payloads,
// result timing, expected grant/latency/response) plus a reset-in-WAIT sequence.
module tb_dnn_job_arb;
    localparam int OUT_W = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dnn_job_arb_if #(.OUT_W(OUT_W)) bus ();

    dnn_job_arb #(.OUT_W(OUT_W), .TIMEOUT(64), .CNT_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic         v0, v1;
        logic [139:0] p0, p1;
        int           d0, d1, d1x;   // cycle index of result pulses, ISSUE = 0, -1 = none
        logic [11:0]  o0, o1;
        int           bp;            // rsp_ready low cycles
        logic         id;
        logic         err;
        logic         chk0;
        int           kresp;         // expected cycle index of first RESP cycle
    } vec_t;

    int tests = 0;
    int fails = 0;
    vec_t tbl [11];

    task automatic chk(input string name, input logic [139:0] act, input logic [139:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [139:0] pay(input int s);
        logic [19:0] u;
        u = 20'(s * 20'h1357 + 20'h0ACE5);
        return {7{u}};
    endfunction

    function automatic vec_t mk(input logic v0, input logic v1, input int s,
                                input int d0, input int d1, input int d1x,
                                input logic [11:0] o0, input logic [11:0] o1,
                                input int bp, input logic id, input logic err,
                                input logic chk0, input int kresp);
        vec_t v;
        v.v0 = v0; v.v1 = v1;
        v.p0 = pay(2 * s); v.p1 = pay(2 * s + 1);
        v.d0 = d0; v.d1 = d1; v.d1x = d1x;
        v.o0 = o0; v.o1 = o1; v.bp = bp;
        v.id = id; v.err = err; v.chk0 = chk0; v.kresp = kresp;
        return v;
    endfunction

    function automatic logic [29:0] outs();
        return {bus.rsp_valid, bus.rsp_id, bus.rsp_out0, bus.rsp_out1, bus.rsp_err,
                bus.dnn_in_ready, bus.req0_ready, bus.req1_ready};
    endfunction

    function automatic logic [139:0] ops();
        return {bus.dnn_x, bus.dnn_w1, bus.dnn_w2};
    endfunction

    task automatic drive(input vec_t j);
        bus.req0_valid = j.v0;
        bus.req1_valid = j.v1;
        bus.req0_x  = j.p0[139:120]; bus.req0_w1 = j.p0[119:40]; bus.req0_w2 = j.p0[39:0];
        bus.req1_x  = j.p1[139:120]; bus.req1_w1 = j.p1[119:40]; bus.req1_w2 = j.p1[39:0];
    endtask

    // Runs one job starting at a negedge with the DUT in IDLE.
    task automatic run_job(input vec_t j, input int n);
        int kr;
        logic bad;
        logic [139:0] gp;
        logic [29:0] snap;
        string tag;
        tag = $sformatf("job%0d", n);
        gp  = j.id ? j.p1 : j.p0;
        drive(j);
        #1;
        chk({tag, ".grant"}, {bus.req1_ready, bus.req0_ready}, j.id ? 2'b10 : 2'b01);
        @(negedge clk);
        if (!(j.v0 && j.v1)) begin
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
        end
        chk({tag, ".in_ready"}, bus.dnn_in_ready, 1'b1);
        chk({tag, ".ops"}, ops(), gp);
        kr  = -1;
        bad = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (k > 0 && bus.rsp_valid) begin
                kr = k;
                break;
            end
            if (bus.req0_ready || bus.req1_ready) bad = 1'b1;
            if (k > 0 && bus.dnn_in_ready) bad = 1'b1;
            bus.dnn_out0_ready = (k == j.d0);
            bus.dnn_out0       = (k == j.d0) ? j.o0 : 12'hBAD;
            bus.dnn_out1_ready = (k == j.d1) || (k == j.d1x);
            bus.dnn_out1       = (k == j.d1) ? j.o1 : (k == j.d1x) ? 12'h7FF : 12'hBAD;
            @(negedge clk);
        end
        bus.dnn_out0_ready = 1'b0;
        bus.dnn_out1_ready = 1'b0;
        chk({tag, ".kresp"}, 140'(kr), 140'(j.kresp));
        chk({tag, ".rsp_id"}, bus.rsp_id, j.id);
        chk({tag, ".rsp_err"}, bus.rsp_err, j.err);
        chk({tag, ".rsp_out1"}, bus.rsp_out1, j.o1);
        if (j.chk0) chk({tag, ".rsp_out0"}, bus.rsp_out0, j.o0);
        snap = outs();
        for (int i = 0; i < j.bp; i++) begin
            @(negedge clk);
            if (outs() !== snap || !bus.rsp_valid) bad = 1'b1;
        end
        chk({tag, ".ops_hold"}, ops(), gp);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk({tag, ".rsp_drop"}, bus.rsp_valid, 1'b0);
        chk({tag, ".stable_noready"}, bad, 1'b0);
    endtask

    initial begin
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.req0_x = 0; bus.req0_w1 = 0; bus.req0_w2 = 0;
        bus.req1_x = 0; bus.req1_w1 = 0; bus.req1_w2 = 0;
        bus.dnn_out0 = 0; bus.dnn_out1 = 0;
        bus.dnn_out0_ready = 0; bus.dnn_out1_ready = 0;
        bus.rsp_ready = 0;

        //            v0 v1 s  d0 d1 d1x  o0      o1      bp id err chk0 kresp
        tbl[0]  = mk(1, 1, 0,  0, 0, -1, 12'h011, 12'h022, 0, 0, 0, 1, 2);
        tbl[1]  = mk(1, 1, 1,  1, 0, -1, 12'h033, 12'h044, 0, 1, 0, 1, 2);
        tbl[2]  = mk(1, 1, 2,  2, 5, -1, 12'h055, 12'h066, 0, 0, 0, 1, 6);
        tbl[3]  = mk(1, 1, 3,  1, 1, -1, 12'h077, 12'h088, 0, 1, 0, 1, 2);
        tbl[4]  = mk(1, 0, 4,  3, 3, -1, 12'h004, 12'h004, 0, 0, 0, 1, 4);
        tbl[4].p0 = {5'd3, 5'h1E, 5'd1, 5'd0, {16{5'd1}}, {8{5'd1}}};
        tbl[5]  = mk(0, 1, 5,  3, 1,  2, 12'h456, 12'h123, 0, 1, 0, 1, 4);
        tbl[6]  = mk(1, 1, 6,  2, 2, -1, 12'h0F0, 12'h00F, 10, 0, 0, 1, 3);
        tbl[7]  = mk(0, 1, 7,  1, 2, -1, 12'h101, 12'h202, 0, 1, 0, 1, 3);
        tbl[8]  = mk(1, 0, 8, -1, 2, -1, 12'h000, 12'h0AA, 0, 0, 1, 0, 65);
        tbl[9]  = mk(0, 1, 9,  2, 1, -1, 12'h3C3, 12'h0C3, 0, 1, 0, 1, 3);
        tbl[10] = mk(1, 1, 10, 1, 1, -1, 12'h5A5, 12'h1E1, 0, 0, 0, 1, 2);

        #2 rst = 1'b1;
        #2;
        chk("reset.outs", outs(), '0);
        chk("reset.ops", ops(), '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < 10; n++) run_job(tbl[n], n);

        // reset while a req1 job sits in WAIT with out1 already captured
        drive(mk(0, 1, 11, -1, -1, -1, 12'h0, 12'h0, 0, 1, 0, 0, 0));
        @(negedge clk);
        bus.req1_valid     = 1'b0;
        bus.dnn_out1_ready = 1'b1;
        bus.dnn_out1       = 12'h321;
        @(negedge clk);
        bus.dnn_out1_ready = 1'b0;
        @(negedge clk);
        chk("midjob.rsp_out1", bus.rsp_out1, 12'h321);
        #2 rst = 1'b1;
        #1;
        chk("rst_wait.outs", outs(), '0);
        chk("rst_wait.ops", ops(), '0);
        @(negedge clk);
        rst = 1'b0;
        run_job(tbl[10], 10);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
